// File: rtl/rotenc_uart_reporter.sv
// Formats each accepted encoder update as "<dir><hex digits>\r\n" and shifts it
// out on an 8N1 UART. Holds at most one newer update while a message is in flight.
module rotenc_uart_reporter #(
  parameter int D_RES    = 16,
  parameter int SYSCLK_F = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [D_RES-1:0] ROT_ENC_CTR,
  input  logic             ENC_CW,
  input  logic             ENC_CCW,
  input  logic             ROTENC_UPATE,
  output logic             UART_TX,
  output logic             TX_BUSY,
  output logic             MSG_DONE
);

  localparam int HEX_N        = D_RES / 4;
  localparam int NBYTES       = HEX_N + 3;
  localparam int CLKS_PER_BIT = SYSCLK_F / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W       = $clog2(NBYTES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [BAUD_W-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [BYTE_W-1:0]  byte_idx_reg, byte_idx_next;
  logic [D_RES-1:0]   msg_val_reg, msg_val_next;
  logic               msg_cw_reg, msg_cw_next;
  logic [D_RES-1:0]   pend_val_reg, pend_val_next;
  logic               pend_cw_reg, pend_cw_next;
  logic               pending_reg, pending_next;
  logic               tx_reg, tx_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               accept;
  logic               bit_end;
  logic [7:0]         msg_bytes [NBYTES];
  logic [7:0]         cur_byte;

  // Direction is fully decided by ENC_CW: both pulses give '+', neither gives '-'.
  logic unused_ccw;
  assign unused_ccw = ENC_CCW;

  assign accept  = ROTENC_UPATE & en;
  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  assign msg_bytes[0]        = msg_cw_reg ? 8'h2B : 8'h2D;
  assign msg_bytes[NBYTES-2] = 8'h0D;
  assign msg_bytes[NBYTES-1] = 8'h0A;

  genvar gi;
  generate
    for (gi = 0; gi < HEX_N; gi++) begin : g_hex
      logic [3:0] nib;
      assign nib = msg_val_reg[D_RES-1-4*gi -: 4];
      // 'A' is 0x41 = 0x37 + 10
      assign msg_bytes[gi+1] = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    end
  endgenerate

  assign cur_byte = msg_bytes[byte_idx_reg];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      msg_val_reg  <= '0;
      msg_cw_reg   <= 1'b0;
      pend_val_reg <= '0;
      pend_cw_reg  <= 1'b0;
      pending_reg  <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      msg_val_reg  <= msg_val_next;
      msg_cw_reg   <= msg_cw_next;
      pend_val_reg <= pend_val_next;
      pend_cw_reg  <= pend_cw_next;
      pending_reg  <= pending_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    msg_val_next  = msg_val_reg;
    msg_cw_next   = msg_cw_reg;
    pend_val_next = pend_val_reg;
    pend_cw_next  = pend_cw_reg;
    pending_next  = pending_reg;
    tx_next       = 1'b1;
    busy_next     = 1'b0;
    done_next     = 1'b0;

    // Every accepted update lands in the one-deep pending slot; latest wins.
    if (accept) begin
      pend_val_next = ROT_ENC_CTR;
      pend_cw_next  = ENC_CW;
      pending_next  = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (pending_reg) begin
          msg_val_next  = pend_val_reg;
          msg_cw_next   = pend_cw_reg;
          pending_next  = accept;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          byte_idx_next = '0;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = S_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (byte_idx_reg == BYTE_LAST) begin
            state_next = S_DONE;
          end else begin
            byte_idx_next = byte_idx_reg + BYTE_W'(1);
            state_next    = S_START;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_DONE: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        byte_idx_next = '0;
        // An update arriving right now is newer than anything pending.
        if (accept) begin
          msg_val_next = ROT_ENC_CTR;
          msg_cw_next  = ENC_CW;
          pending_next = 1'b0;
          state_next   = S_START;
        end else if (pending_reg) begin
          msg_val_next = pend_val_reg;
          msg_cw_next  = pend_cw_reg;
          pending_next = 1'b0;
          state_next   = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // DATA is only entered with the byte index unchanged, so cur_byte is valid here.
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = cur_byte[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
  end

  assign UART_TX  = tx_reg;
  assign TX_BUSY  = busy_reg;
  assign MSG_DONE = done_reg;

endmodule
